// File: rtl/sap_control_sequencer.sv
// SAP-1 microcoded control sequencer: walks fetch/execute T-states per tick and decodes the control word.
// Optional build macro SAP_CTRL_CONDJUMP_EN enables JC/JZ; without it those opcodes decode as NOP.
module sap_control_sequencer #(
  parameter int EARLY_END = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  opcode,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted,
  output logic        flag_c,
  output logic        flag_z
);

  localparam logic [15:0] C_HLT = 16'h0001;
  localparam logic [15:0] C_MI  = 16'h0002;
  localparam logic [15:0] C_RI  = 16'h0004;
  localparam logic [15:0] C_RO  = 16'h0008;
  localparam logic [15:0] C_IO  = 16'h0010;
  localparam logic [15:0] C_II  = 16'h0020;
  localparam logic [15:0] C_AI  = 16'h0040;
  localparam logic [15:0] C_AO  = 16'h0080;
  localparam logic [15:0] C_EO  = 16'h0100;
  localparam logic [15:0] C_SU  = 16'h0200;
  localparam logic [15:0] C_BI  = 16'h0400;
  localparam logic [15:0] C_OI  = 16'h0800;
  localparam logic [15:0] C_CE  = 16'h1000;
  localparam logic [15:0] C_CO  = 16'h2000;
  localparam logic [15:0] C_J   = 16'h4000;
  localparam logic [15:0] C_FI  = 16'h8000;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  tstate_e     step_q, step_d;
  logic        halted_q, halted_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic [15:0] micro;
  tstate_e     last_t;

  // Raw microcode for the current step, ignoring the halted freeze.
  always_comb begin
    micro = '0;
    case (step_q)
      T0: micro = C_CO | C_MI;
      T1: micro = C_RO | C_II | C_CE;
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: micro = C_IO | C_MI;
          OP_LDI: micro = C_IO | C_AI;
          OP_JMP: micro = C_IO | C_J;
`ifdef SAP_CTRL_CONDJUMP_EN
          OP_JC:  micro = flag_c_q ? (C_IO | C_J) : 16'h0000;
          OP_JZ:  micro = flag_z_q ? (C_IO | C_J) : 16'h0000;
`endif
          OP_OUT: micro = C_AO | C_OI;
          OP_HLT: micro = C_HLT;
          default: micro = '0;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: micro = C_RO | C_AI;
          OP_ADD, OP_SUB: micro = C_RO | C_BI;
          OP_STA: micro = C_AO | C_RI;
          default: micro = '0;
        endcase
      end
      T4: begin
        case (opcode)
          OP_ADD: micro = C_EO | C_AI | C_FI;
          OP_SUB: micro = C_EO | C_AI | C_SU | C_FI;
          default: micro = '0;
        endcase
      end
      default: micro = '0;
    endcase
  end

  // Last non-empty microstep of each instruction, used only for early return to T0.
  always_comb begin
    last_t = T1;
    case (opcode)
      OP_LDA, OP_STA: last_t = T3;
      OP_ADD, OP_SUB: last_t = T4;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_t = T2;
`ifdef SAP_CTRL_CONDJUMP_EN
      OP_JC, OP_JZ: last_t = T2;
`endif
      default: last_t = T1;
    endcase
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (tick && !halted_q) begin
      if ((micro & C_HLT) != 16'h0000) begin
        halted_d = 1'b1;
      end else if (step_q == T4 || (EARLY_END != 0 && step_q == last_t)) begin
        step_d = T0;
      end else begin
        step_d = tstate_e'(step_q + 3'd1);
      end
      if ((micro & C_FI) != 16'h0000) begin
        flag_c_d = alu_c;
        flag_z_d = alu_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign ctrl   = halted_q ? C_HLT : micro;
  assign step   = step_q;
  assign halted = halted_q;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: fixed-length and early-end instances share stimulus.
module tb_sap_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        alu_c = 1'b0;
  logic        alu_z = 1'b0;

  logic [15:0] ctrl_m, ctrl_e;
  logic [2:0]  step_m, step_e;
  logic        halted_m, halted_e, fc_m, fc_e, fz_m, fz_e;

`ifdef SAP_CTRL_CONDJUMP_EN
  localparam logic [15:0] JTAKE = 16'h4010;
`else
  localparam logic [15:0] JTAKE = 16'h0000;
`endif

  sap_control_sequencer #(.EARLY_END(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .opcode(opcode), .alu_c(alu_c), .alu_z(alu_z),
    .ctrl(ctrl_m), .step(step_m), .halted(halted_m), .flag_c(fc_m), .flag_z(fz_m)
  );

  sap_control_sequencer #(.EARLY_END(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .tick(tick), .opcode(opcode), .alu_c(alu_c), .alu_z(alu_z),
    .ctrl(ctrl_e), .step(step_e), .halted(halted_e), .flag_c(fc_e), .flag_z(fz_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        rst_n;
    logic        tick;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  s;
    logic [15:0] w;
    logic        h;
    logic        fc;
    logic        fz;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  function automatic vec_t mk(input logic sel, input logic r, input logic t, input logic [3:0] op,
                              input logic c, input logic z, input logic [2:0] s, input logic [15:0] w,
                              input logic h, input logic fc, input logic fz);
    vec_t v;
    v.sel = sel; v.rst_n = r; v.tick = t; v.op = op; v.c = c; v.z = z;
    v.s = s; v.w = w; v.h = h; v.fc = fc; v.fz = fz;
    return v;
  endfunction

  // Full five-step instruction with no flag write; fetch rows carry a stale HLT opcode.
  function automatic void add_plain(input logic [3:0] op, input logic [15:0] w2, input logic [15:0] w3,
                                    input logic fc, input logic fz);
    tbl.push_back(mk(0, 1, 1, 4'hF, 0, 0, 3'd1, 16'h1028, 0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   0, 0, 3'd2, w2,       0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   0, 0, 3'd3, w3,       0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   0, 0, 3'd4, 16'h0000, 0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   0, 0, 3'd0, 16'h2002, 0, fc, fz));
  endfunction

  // ADD/SUB: non-FI edges drive alu inputs opposite to the final values so stray sampling shows.
  function automatic void add_alu(input logic [3:0] op, input logic [15:0] w4, input logic c, input logic z,
                                  input logic fc, input logic fz);
    tbl.push_back(mk(0, 1, 1, 4'hF, ~c, ~z, 3'd1, 16'h1028, 0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   ~c, ~z, 3'd2, 16'h0012, 0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   ~c, ~z, 3'd3, 16'h0408, 0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   ~c, ~z, 3'd4, w4,       0, fc, fz));
    tbl.push_back(mk(0, 1, 1, op,   c,  z,  3'd0, 16'h2002, 0, c,  z));
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
    if (got !== want) begin
      n_miscompares++;
      $display("[TB] FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_miscompares++;
      $display("[TB] FAIL scoreboard vec %0d: got empty queue expected an entry", idx);
      return;
    end
    e = exp_q.pop_front();
    n_vectors++;
    if (e.sel == 1'b0) begin
      cmp("step",   idx, {13'd0, step_m}, {13'd0, e.s});
      cmp("ctrl",   idx, ctrl_m, e.w);
      cmp("halted", idx, {15'd0, halted_m}, {15'd0, e.h});
      cmp("flag_c", idx, {15'd0, fc_m}, {15'd0, e.fc});
      cmp("flag_z", idx, {15'd0, fz_m}, {15'd0, e.fz});
    end else begin
      cmp("ee_step",   idx, {13'd0, step_e}, {13'd0, e.s});
      cmp("ee_ctrl",   idx, ctrl_e, e.w);
      cmp("ee_halted", idx, {15'd0, halted_e}, {15'd0, e.h});
      cmp("ee_flag_c", idx, {15'd0, fc_e}, {15'd0, e.fc});
      cmp("ee_flag_z", idx, {15'd0, fz_e}, {15'd0, e.fz});
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check just after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    rst_n  = v.rst_n;
    tick   = v.tick;
    opcode = v.op;
    alu_c  = v.c;
    alu_z  = v.z;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    int idx;
    // Reset with tick high, then idle.
    tbl.push_back(mk(0, 0, 1, 4'h0, 0, 0, 3'd0, 16'h2002, 0, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 3'd0, 16'h2002, 0, 0, 0));
    add_alu(4'b0010, 16'h8140, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl.push_back(mk(0, 1, 0, 4'hF, 0, 0, 3'd0, 16'h2002, 0, 1, 0));
    add_alu(4'b0011, 16'h8340, 1'b0, 1'b1, 1'b1, 1'b0);
    // LDA with a tick-low hold in the middle of T2.
    tbl.push_back(mk(0, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0001, 0, 0, 3'd2, 16'h0012, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 0, 0, 3'd2, 16'h0012, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0001, 0, 0, 3'd3, 16'h0048, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0001, 0, 0, 3'd4, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0001, 0, 0, 3'd0, 16'h2002, 0, 0, 1));
    add_plain(4'b0100, 16'h0012, 16'h0084, 1'b0, 1'b1);
    add_plain(4'b0101, 16'h0050, 16'h0000, 1'b0, 1'b1);
    add_plain(4'b1110, 16'h0880, 16'h0000, 1'b0, 1'b1);
    add_plain(4'b0110, 16'h4010, 16'h0000, 1'b0, 1'b1);
    add_plain(4'b1001, 16'h0000, 16'h0000, 1'b0, 1'b1);
    add_plain(4'b0111, 16'h0000, 16'h0000, 1'b0, 1'b1);
    add_plain(4'b1000, JTAKE,    16'h0000, 1'b0, 1'b1);
    add_alu(4'b0010, 16'h8140, 1'b1, 1'b0, 1'b0, 1'b1);
    add_plain(4'b0111, JTAKE,    16'h0000, 1'b1, 1'b0);
    add_plain(4'b1000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    // HLT freezes at T2, ignores ticks, cleared only by reset.
    tbl.push_back(mk(0, 1, 1, 4'hF, 0, 0, 3'd1, 16'h1028, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'hF, 0, 0, 3'd2, 16'h0001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'hF, 0, 0, 3'd2, 16'h0001, 1, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 4'h2, 1, 1, 3'd2, 16'h0001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'hF, 0, 0, 3'd0, 16'h2002, 0, 0, 0));
    // Reset during ADD T3 aborts it and clears flags.
    add_alu(4'b0010, 16'h8140, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl.push_back(mk(0, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0010, 0, 0, 3'd2, 16'h0012, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0010, 0, 0, 3'd3, 16'h0408, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 1, 1, 3'd0, 16'h2002, 0, 0, 0));

    idx = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], idx);
      idx++;
    end

    // Early-end instance: LDI, NOP, SUB, LDA sequences.
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0101, 0, 0, 3'd2, 16'h0050, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0101, 0, 0, 3'd0, 16'h2002, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b1001, 0, 0, 3'd0, 16'h2002, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0011, 0, 0, 3'd2, 16'h0012, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0011, 0, 0, 3'd3, 16'h0408, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0011, 0, 0, 3'd4, 16'h8340, 0, 0, 0), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0011, 1, 1, 3'd0, 16'h2002, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0001, 0, 0, 3'd2, 16'h0012, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0001, 0, 0, 3'd3, 16'h0048, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0001, 0, 0, 3'd0, 16'h2002, 0, 1, 1), idx++);
    // Taken JC ends after T2; as a NOP it ends after T1.
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 1, 1), idx++);
`ifdef SAP_CTRL_CONDJUMP_EN
    applyStimulus(mk(1, 1, 1, 4'b0111, 0, 0, 3'd2, 16'h4010, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'b0111, 0, 0, 3'd0, 16'h2002, 0, 1, 1), idx++);
`else
    applyStimulus(mk(1, 1, 1, 4'b0111, 0, 0, 3'd0, 16'h2002, 0, 1, 1), idx++);
`endif
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd1, 16'h1028, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd2, 16'h0001, 0, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd2, 16'h0001, 1, 1, 1), idx++);
    applyStimulus(mk(1, 1, 1, 4'hF,    0, 0, 3'd2, 16'h0001, 1, 1, 1), idx++);
    applyStimulus(mk(1, 0, 1, 4'hF,    0, 0, 3'd0, 16'h2002, 0, 0, 0), idx++);

    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
